sqrt_pwl_eval: RTL and testbench

- Pipelined piecewise-linear square-root evaluator for the Box-Muller datapath.
- Computes f = sqrt(e), where e = -2ln(u0) comes from the log stage; f feeds the f*sin/f*cos multiplier stage.
- Does range reduction: leading-one detect, normalise, even/odd exponent split.
- Drives the addresses of two combinational coefficient ROMs and evaluates y = c1*xb + c0.
- Sqrt2_Coeffs sits on the lo port, covering argument [1,2). A companion table with the same format sits on the hi port, covering argument [2,4).

---
 rtl/sqrt_pwl_eval_pkg.sv | 53 +++++
 rtl/sqrt_pwl_eval_lzd31.sv | 16 +
 rtl/sqrt_pwl_eval.sv | 81 ++++++++
 tb/tb_sqrt_pwl_eval.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sqrt_pwl_eval_pkg.sv
// sqrt_pwl_eval_pkg: shared widths, coefficient packing and stage records for the sqrt evaluator
// No ports. Provides localparams and the packed per-stage register records.
package sqrt_pwl_eval_pkg;
    localparam int E_W        = 31;
    localparam int F_W        = 17;
    localparam int SEG_W      = 6;
    localparam int C1_MSB     = 31;
    localparam int C1_LSB     = 20;
    localparam int C1_W       = C1_MSB - C1_LSB + 1;
    localparam int C0_W       = 20;
    localparam int XB_W       = 17;
    localparam int P_W        = 5;
    localparam int K_W        = 6;
    localparam int S_W        = 5;
    localparam int IX_W       = SEG_W + XB_W;
    localparam int FRAC_DROP  = E_W - 1 - IX_W;
    localparam int PROD_W     = C1_W + XB_W;
    localparam int Y_W        = 21;
    localparam int EXP_BIAS   = 26;
    localparam int PROD_SHIFT = 16;
    localparam int OUT_SHIFT  = 4;

    typedef struct packed {
        logic             v;
        logic             zero;
        logic             sel;
        logic [SEG_W-1:0] idx;
        logic [XB_W-1:0]  xb;
        logic [S_W-1:0]   s;
    } s1_t;

    typedef struct packed {
        logic            v;
        logic            zero;
        logic [C1_W-1:0] c1;
        logic [C0_W-1:0] c0;
        logic [XB_W-1:0] xb;
        logic [S_W-1:0]  s;
    } s2_t;

    typedef struct packed {
        logic              v;
        logic              zero;
        logic [PROD_W-1:0] prod;
        logic [C0_W-1:0]   c0;
        logic [S_W-1:0]    s;
    } s3_t;

    typedef struct packed {
        logic           v;
        logic [F_W-1:0] f;
    } s4_t;
endpackage

// File: rtl/sqrt_pwl_eval_lzd31.sv
// lzd31: combinational leading-one detector for a 31-bit operand
// a in 31: operand; p out 5: position of the highest set bit (0 when a==0); zero out 1: a==0
module lzd31
    import sqrt_pwl_eval_pkg::*;
(
    input  logic [E_W-1:0] a,
    output logic [P_W-1:0] p,
    output logic           zero
);
    always_comb begin
        p = '0;
        for (int i = 0; i < E_W; i++)
            if (a[i]) p = P_W'(i);
        zero = (a == '0);
    end
endmodule

// File: rtl/sqrt_pwl_eval.sv
// sqrt_pwl_eval: 4-stage piecewise-linear sqrt, f = sqrt(e), UQ5.26 in, UQ4.13 out
// clk/reset(async, active-high)/en(advance) ; valid_in, e_in[30:0] in ;
// lo_addr/hi_addr[5:0] out to the [1,2) and [2,4) coefficient ROMs, lo_data/hi_data[31:0] back ;
// valid_out, f_out[16:0] out, 4 enabled cycles after valid_in.
module sqrt_pwl_eval
    import sqrt_pwl_eval_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             valid_in,
    input  logic [E_W-1:0]   e_in,
    output logic [SEG_W-1:0] lo_addr,
    input  logic [31:0]      lo_data,
    output logic [SEG_W-1:0] hi_addr,
    input  logic [31:0]      hi_data,
    output logic             valid_out,
    output logic [F_W-1:0]   f_out
);
    logic [P_W-1:0] p;
    logic           zero;
    logic [E_W-1:0] norm;
    logic [K_W-1:0] k;
    logic [31:0]    coef;
    logic [Y_W-1:0] y;
    logic [S_W-1:0] sh;
    s1_t s1_d, s1_q;
    s2_t s2_d, s2_q;
    s3_t s3_d, s3_q;
    s4_t s4_d, s4_q;

    lzd31 u_lzd (.a(e_in), .p(p), .zero(zero));

    always_comb begin
        // Left-justify so the leading one lands on bit 30; the bits below it are the mantissa fraction.
        norm = e_in << (P_W'(E_W - 1) - p);
        k = {1'b0, p} - K_W'(EXP_BIAS);
        s1_d.v = valid_in;
        s1_d.zero = zero;
        {s1_d.idx, s1_d.xb} = IX_W'(norm >> FRAC_DROP);
        // k[5:1] is floor(k/2) in two's complement; k[0] picks the [2,4) table for odd exponents.
        s1_d.s = k[K_W-1:1];
        s1_d.sel = k[0];
        coef = s1_q.sel ? hi_data : lo_data;
        s2_d.v = s1_q.v;
        s2_d.zero = s1_q.zero;
        s2_d.c1 = coef[C1_MSB:C1_LSB];
        s2_d.c0 = coef[C0_W-1:0];
        s2_d.xb = s1_q.xb;
        s2_d.s = s1_q.s;
        s3_d.v = s2_q.v;
        s3_d.zero = s2_q.zero;
        s3_d.prod = PROD_W'(s2_q.c1) * PROD_W'(s2_q.xb);
        s3_d.c0 = s2_q.c0;
        s3_d.s = s2_q.s;
        y = Y_W'(s3_q.c0) + Y_W'(s3_q.prod >> PROD_SHIFT);
        // y*2^s/16 with s<=2 is always a right shift by 4-s (2..17).
        sh = S_W'(OUT_SHIFT) - s3_q.s;
        s4_d.v = s3_q.v;
        s4_d.f = s3_q.zero ? '0 : F_W'(y >> sh);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
            s4_q <= '0;
        end else if (en) begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
            s4_q <= s4_d;
        end
    end

    assign lo_addr   = s1_q.idx;
    assign hi_addr   = s1_q.idx;
    assign valid_out = s4_q.v;
    assign f_out     = s4_q.f;
endmodule

// File: tb/tb_sqrt_pwl_eval.sv
// tb_sqrt_pwl_eval: scoreboard bench for the piecewise-linear sqrt pipeline
module tb_sqrt_pwl_eval;
    logic        clk, reset, en, valid_in;
    logic [30:0] e_in;
    logic [5:0]  lo_addr, hi_addr;
    logic [31:0] lo_data, hi_data;
    logic        valid_out;
    logic [16:0] f_out;
    logic [31:0] lo_rom [64];
    logic [31:0] hi_rom [64];
    logic [16:0] exp_q [$];
    logic [16:0] exp_f;
    logic        adv;
    int          n_chk, n_fail;

    sqrt_pwl_eval dut (
        .clk(clk), .reset(reset), .en(en), .valid_in(valid_in), .e_in(e_in),
        .lo_addr(lo_addr), .lo_data(lo_data), .hi_addr(hi_addr), .hi_data(hi_data),
        .valid_out(valid_out), .f_out(f_out)
    );

    assign lo_data = lo_rom[lo_addr];
    assign hi_data = hi_rom[hi_addr];

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic logic [16:0] model(input logic [30:0] e);
        longint ev, frac, word, c1, c0, xb, y;
        int p, k, s, idx;
        if (e == 0) return '0;
        ev = longint'(e);
        p = 0;
        for (int i = 0; i < 31; i++)
            if (ev >= (longint'(1) << i)) p = i;
        k = p - 26;
        frac = (ev << (30 - p)) & 'h3FFF_FFFF;
        idx = int'(frac >> 24);
        xb = (frac >> 7) & 'h1FFFF;
        word = (k % 2 != 0) ? longint'(hi_rom[idx]) : longint'(lo_rom[idx]);
        c1 = word >> 20;
        c0 = word & 'hFFFFF;
        y = c0 + (c1 * xb) / 65536;
        s = (k >= 0) ? k / 2 : -((1 - k) / 2);
        return 17'((y << (s + 13)) >> 17);
    endfunction

    task automatic step(input logic v, input logic [30:0] e, input logic en_v);
        @(negedge clk);
        adv = en;
        valid_in = v;
        e_in = e;
        en = en_v;
        if (v && en_v) exp_q.push_back(model(e));
    endtask

    task automatic fill_random();
        for (int i = 0; i < 64; i++) begin
            lo_rom[i] = $urandom();
            hi_rom[i] = $urandom();
        end
    endtask

    task automatic test_reset();
        reset = 1;
        #3;
        n_chk++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b want=0", valid_out); end
        n_chk++; if (f_out !== 17'h0) begin n_fail++; $display("FAIL reset_f got=%h want=0", f_out); end
        n_chk++; if (lo_addr !== 6'h0) begin n_fail++; $display("FAIL reset_lo_addr got=%h want=0", lo_addr); end
        n_chk++; if (hi_addr !== 6'h0) begin n_fail++; $display("FAIL reset_hi_addr got=%h want=0", hi_addr); end
        @(negedge clk);
        reset = 0;
    endtask

    task automatic test_exact4();
        int lat = 0;
        lo_rom[0] = 32'h1FE2_01FC;
        step(1, 31'h1000_0000, 1);
        for (int i = 1; i <= 8; i++) begin
            step(0, '0, 1);
            if (adv && valid_out) begin
                if (lat == 0) lat = i;
                exp_f = exp_q.size() != 0 ? exp_q.pop_front() : 'x;
                n_chk++; if (f_out !== exp_f) begin n_fail++; $display("FAIL exact4_sb got=%h want=%h", f_out, exp_f); end
                n_chk++; if (f_out !== 17'h403F) begin n_fail++; $display("FAIL exact4 got=%h want=403f", f_out); end
            end
        end
        n_chk++; if (lat != 4) begin n_fail++; $display("FAIL latency got=%0d want=4", lat); end
    endtask

    task automatic test_max();
        lo_rom[63] = 32'h16A2_D2A8;
        step(1, 31'h7FFF_FFFF, 1);
        step(0, '0, 1);
        n_chk++; if (lo_addr !== 6'd63) begin n_fail++; $display("FAIL max_lo_addr got=%0d want=63", lo_addr); end
        n_chk++; if (hi_addr !== 6'd63) begin n_fail++; $display("FAIL max_hi_addr got=%0d want=63", hi_addr); end
        for (int i = 0; i < 7; i++) begin
            step(0, '0, 1);
            if (adv && valid_out) begin
                exp_f = exp_q.size() != 0 ? exp_q.pop_front() : 'x;
                n_chk++; if (f_out !== exp_f) begin n_fail++; $display("FAIL max_sb got=%h want=%h", f_out, exp_f); end
                n_chk++; if (f_out !== 17'hB55E) begin n_fail++; $display("FAIL max got=%h want=b55e", f_out); end
            end
        end
    endtask

    task automatic test_odd();
        int n_out = 0;
        hi_rom[0] = 32'h123A_BCDE;
        lo_rom[0] = 32'h1FE2_01FC;
        step(1, 31'h0800_0000, 1);
        step(0, '0, 1);
        n_chk++; if (hi_addr !== 6'd0) begin n_fail++; $display("FAIL odd_hi_addr got=%0d want=0", hi_addr); end
        lo_rom[0] = 32'hFFFF_FFFF;
        step(1, 31'h0800_0000, 1);
        for (int i = 0; i < 8; i++) begin
            step(0, '0, 1);
            if (adv && valid_out) begin
                n_out++;
                exp_f = exp_q.size() != 0 ? exp_q.pop_front() : 'x;
                n_chk++; if (f_out !== exp_f) begin n_fail++; $display("FAIL odd_sb got=%h want=%h", f_out, exp_f); end
                n_chk++; if (f_out !== 17'h0ABCD) begin n_fail++; $display("FAIL odd got=%h want=0abcd", f_out); end
            end
        end
        n_chk++; if (n_out != 2) begin n_fail++; $display("FAIL odd_count got=%0d want=2", n_out); end
        lo_rom[0] = 32'h1FE2_01FC;
    endtask

    task automatic test_zero_b2b();
        logic [16:0] outs [$];
        int          when [$];
        step(1, '0, 1);
        step(1, 31'h1000_0000, 1);
        step(1, '0, 1);
        for (int i = 0; i < 8; i++) begin
            step(0, '0, 1);
            if (adv && valid_out) begin
                outs.push_back(f_out);
                when.push_back(i);
                exp_f = exp_q.size() != 0 ? exp_q.pop_front() : 'x;
                n_chk++; if (f_out !== exp_f) begin n_fail++; $display("FAIL b2b_sb got=%h want=%h", f_out, exp_f); end
            end
        end
        n_chk++;
        if (outs.size() != 3) begin
            n_fail++; $display("FAIL b2b_count got=%0d want=3", outs.size());
        end else begin
            n_chk += 3;
            if (outs[0] !== 17'h0 || outs[1] !== 17'h403F || outs[2] !== 17'h0) begin
                n_fail++; $display("FAIL b2b_values got=%h,%h,%h want=0,403f,0", outs[0], outs[1], outs[2]);
            end
            if (when[2] - when[0] != 2) begin n_fail++; $display("FAIL b2b_spacing got=%0d want=2", when[2] - when[0]); end
        end
    endtask

    task automatic test_stall();
        int          n_out = 0;
        logic        pv;
        logic [16:0] pf;
        logic [5:0]  pa;
        fill_random();
        for (int i = 0; i < 18; i++) begin
            pv = valid_out; pf = f_out; pa = lo_addr;
            if (i < 3) step(1, 31'($urandom_range(32'h7FFF_FFFF, 1)), 1);
            else step(0, '0, !(i >= 5 && i < 10));
            if (!adv) begin
                n_chk++;
                if (valid_out !== pv || f_out !== pf || lo_addr !== pa) begin
                    n_fail++; $display("FAIL stall_hold got=%b/%h/%h want=%b/%h/%h", valid_out, f_out, lo_addr, pv, pf, pa);
                end
            end else if (valid_out) begin
                n_out++;
                exp_f = exp_q.size() != 0 ? exp_q.pop_front() : 'x;
                n_chk++; if (f_out !== exp_f) begin n_fail++; $display("FAIL stall_sb got=%h want=%h", f_out, exp_f); end
            end
        end
        n_chk++; if (n_out != 3 || exp_q.size() != 0) begin n_fail++; $display("FAIL stall_count got=%0d left=%0d want=3 left=0", n_out, exp_q.size()); end
    endtask

    task automatic test_random();
        logic        pv;
        logic [16:0] pf;
        for (int i = 0; i < 100; i++) begin
            pv = valid_out; pf = f_out;
            if (i < 90) step(1'($urandom_range(1, 0)), 31'($urandom() >> $urandom_range(31, 1)), $urandom_range(3, 0) != 0);
            else step(0, '0, 1);
            if (!adv) begin
                n_chk++;
                if (valid_out !== pv || f_out !== pf) begin n_fail++; $display("FAIL rand_hold got=%b/%h want=%b/%h", valid_out, f_out, pv, pf); end
            end else if (valid_out) begin
                exp_f = exp_q.size() != 0 ? exp_q.pop_front() : 'x;
                n_chk++; if (f_out !== exp_f) begin n_fail++; $display("FAIL rand_sb got=%h want=%h", f_out, exp_f); end
            end
        end
        n_chk++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rand_left got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 7; i++) begin
            step(1, 31'($urandom_range(32'h7FFF_FFFF, 32'h0400_0000)), 1);
            if (adv && valid_out) begin
                exp_f = exp_q.size() != 0 ? exp_q.pop_front() : 'x;
                n_chk++; if (f_out !== exp_f) begin n_fail++; $display("FAIL rmid_sb got=%h want=%h", f_out, exp_f); end
            end
        end
        #2;
        reset = 1;
        valid_in = 0;
        exp_q.delete();
        #1;
        n_chk++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL rmid_valid got=%b want=0", valid_out); end
        n_chk++; if (f_out !== 17'h0) begin n_fail++; $display("FAIL rmid_f got=%h want=0", f_out); end
        n_chk++; if (lo_addr !== 6'h0) begin n_fail++; $display("FAIL rmid_addr got=%h want=0", lo_addr); end
        @(negedge clk);
        reset = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, '0, 1);
            n_chk++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL rmid_after cycle=%0d got=%b want=0", i, valid_out); end
        end
    endtask

    initial begin
        n_chk = 0; n_fail = 0; adv = 0;
        en = 1; valid_in = 0; e_in = '0;
        fill_random();
        test_reset();
        test_exact4();
        test_max();
        test_odd();
        test_zero_b2b();
        test_stall();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule
